// File: rtl/comb_pattern_driver.sv
// LFSR-driven stimulus generator for the combLogic netlist: one vector per window,
// settle then observe the single output, and compact responses into a MISR signature.
module comb_pattern_driver #(
    parameter int               WIDTH        = 26,
    parameter logic [WIDTH-1:0] SEED         = 26'h0000001,
    parameter int               NUM_PATTERNS = 256,
    parameter int               SETTLE       = 4,
    parameter int               OBSERVE      = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] pat_out_o,
    input  logic             dut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      signature_o,
    output logic [15:0]      ones_count_o,
    output logic [15:0]      unstable_count_o,
    output logic [15:0]      pattern_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE_ST,
        OBSERVE_ST,
        ACCUM,
        DONE
    } state_t;

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_EFF   = (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;
    localparam logic [7:0]       SETTLE_END = 8'(SETTLE - 1);
    localparam logic [7:0]       OBS_END    = 8'(OBSERVE - 1);
    localparam logic [15:0]      LAST_PAT   = 16'(NUM_PATTERNS - 1);

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] pat_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      sig_q;
    logic [15:0]      ones_q;
    logic [15:0]      unst_q;
    logic [15:0]      pcnt_q;
    logic             ref_q;
    logic             unstable_q;
    logic             resp_q;

    logic [WIDTH-1:0] pat_d;
    logic [15:0]      sig_d;

    assign pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1] ^ pat_q[5] ^ pat_q[1] ^ pat_q[0]};
    assign sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3] ^ resp_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sig_q      <= 16'hFFFF;
            ones_q     <= '0;
            unst_q     <= '0;
            pcnt_q     <= '0;
            ref_q      <= 1'b0;
            unstable_q <= 1'b0;
            resp_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        pat_q      <= SEED_EFF;
                        sig_q      <= 16'hFFFF;
                        ones_q     <= '0;
                        unst_q     <= '0;
                        pcnt_q     <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        cnt_q      <= '0;
                        unstable_q <= 1'b0;
                        state_q    <= SETTLE_ST;
                    end
                end
                SETTLE_ST: begin
                    if (cnt_q == SETTLE_END) begin
                        cnt_q   <= '0;
                        state_q <= OBSERVE_ST;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                OBSERVE_ST: begin
                    // First sample is the reference; any later disagreement marks the pattern unstable.
                    if (cnt_q == 8'd0) begin
                        ref_q <= dut_out_i;
                    end else if (dut_out_i != ref_q) begin
                        unstable_q <= 1'b1;
                    end
                    if (cnt_q == OBS_END) begin
                        resp_q  <= dut_out_i;
                        cnt_q   <= '0;
                        state_q <= ACCUM;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ACCUM: begin
                    sig_q  <= sig_d;
                    ones_q <= ones_q + {15'd0, resp_q};
                    unst_q <= unst_q + {15'd0, unstable_q};
                    pcnt_q <= pcnt_q + 16'd1;
                    if (pcnt_q == LAST_PAT) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        pat_q      <= pat_d;
                        unstable_q <= 1'b0;
                        state_q    <= SETTLE_ST;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pat_out_o        = pat_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign signature_o      = sig_q;
    assign ones_count_o     = ones_q;
    assign unstable_count_o = unst_q;
    assign pattern_count_o  = pcnt_q;

endmodule

// File: tb/tb_comb_pattern_driver.sv
// Directed bench for comb_pattern_driver: three instances with different parameter sets,
// expected run results queued at start and checked when done rises.
module tb_comb_pattern_driver;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] ones;
        logic [15:0] unst;
        logic [15:0] pcnt;
        logic [25:0] pat;
        bit          full;
    } exp_t;

    localparam int WA = 6;
    localparam int WC = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        startA, startB, startC;
    logic        dinA, dinB, dinC;
    logic [25:0] patA, patB, patC;
    logic        busyA, busyB, busyC, doneA, doneB, doneC;
    logic [15:0] sigA, sigB, sigC, onesA, onesB, onesC;
    logic [15:0] unstA, unstB, unstC, pcntA, pcntB, pcntC;
    logic        tog = 1'b0;
    logic        dly = 1'b0;
    logic [1:0]  modeA, modeB;
    logic        constA, constB;

    int checks = 0;
    int errors = 0;
    exp_t        sbq[$];
    logic [25:0] patQ[$];

    // Bench-side stand-ins for the netlist: a free-running toggle and a one-cycle-delayed pat_out[0].
    always @(posedge clk) tog <= ~tog;
    always @(posedge clk) dly <= patC[0];

    assign dinA = (modeA == 2'd3) ? tog : constA;
    assign dinB = (modeB == 2'd3) ? tog : constB;
    assign dinC = dly;

    comb_pattern_driver #(.NUM_PATTERNS(4), .SETTLE(2), .OBSERVE(3)) dutA (
        .clk_i(clk), .rst_i(rst), .start_i(startA), .pat_out_o(patA), .dut_out_i(dinA),
        .busy_o(busyA), .done_o(doneA), .signature_o(sigA), .ones_count_o(onesA),
        .unstable_count_o(unstA), .pattern_count_o(pcntA));

    comb_pattern_driver #(.SEED(26'h0), .NUM_PATTERNS(4), .SETTLE(2), .OBSERVE(1)) dutB (
        .clk_i(clk), .rst_i(rst), .start_i(startB), .pat_out_o(patB), .dut_out_i(dinB),
        .busy_o(busyB), .done_o(doneB), .signature_o(sigB), .ones_count_o(onesB),
        .unstable_count_o(unstB), .pattern_count_o(pcntB));

    comb_pattern_driver #(.NUM_PATTERNS(256), .SETTLE(4), .OBSERVE(4)) dutC (
        .clk_i(clk), .rst_i(rst), .start_i(startC), .pat_out_o(patC), .dut_out_i(dinC),
        .busy_o(busyC), .done_o(doneC), .signature_o(sigC), .ones_count_o(onesC),
        .unstable_count_o(unstC), .pattern_count_o(pcntC));

    function automatic logic [25:0] lfsrNext(input logic [25:0] p);
        return {p[24:0], p[25] ^ p[5] ^ p[1] ^ p[0]};
    endfunction

    // Pattern-level model: mode 0/1 constant output, 2 follows pat[0], 3 toggles every cycle.
    function automatic exp_t runModel(input logic [25:0] seed, input int np, input int mode, input int obs);
        exp_t        e;
        logic [25:0] p;
        logic        r;
        p      = (seed == 26'h0) ? 26'h1 : seed;
        e.sig  = 16'hFFFF;
        e.ones = '0;
        e.unst = '0;
        for (int k = 0; k < np; k++) begin
            case (mode)
                1:       r = 1'b1;
                2:       r = p[0];
                default: r = 1'b0;
            endcase
            e.sig  = {e.sig[14:0], e.sig[15] ^ e.sig[14] ^ e.sig[12] ^ e.sig[3] ^ r};
            e.ones = e.ones + {15'd0, r};
            if (mode == 3 && obs > 1) e.unst = e.unst + 16'd1;
            if (k < np - 1) p = lfsrNext(p);
        end
        e.pcnt = 16'(np);
        e.pat  = p;
        e.full = (mode != 3);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic getOut(input int which, output logic [25:0] pat, output logic [15:0] sig,
                          output logic [15:0] ones, output logic [15:0] unst, output logic [15:0] pcnt,
                          output logic busy, output logic done);
        case (which)
            0:       begin pat = patA; sig = sigA; ones = onesA; unst = unstA; pcnt = pcntA; busy = busyA; done = doneA; end
            1:       begin pat = patB; sig = sigB; ones = onesB; unst = unstB; pcnt = pcntB; busy = busyB; done = doneB; end
            default: begin pat = patC; sig = sigC; ones = onesC; unst = unstC; pcnt = pcntC; busy = busyC; done = doneC; end
        endcase
    endtask

    task automatic applyStimulus(input bit a, input bit b, input bit c);
        startA = a;
        startB = b;
        startC = c;
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
    endtask

    task automatic waitDone(input int which, input int budget, output int cycles);
        logic [25:0] p;
        logic [15:0] s, o, u, n;
        logic        bz, dn;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            getOut(which, p, s, o, u, n, bz, dn);
        end while (!dn && cycles < budget);
        checkOutput($sformatf("done_seen_%0d", which), {31'd0, dn}, 32'd1);
    endtask

    task automatic checkResult(input int which, input string tag);
        exp_t        e;
        logic [25:0] p;
        logic [15:0] s, o, u, n;
        logic        bz, dn;
        if (sbq.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            getOut(which, p, s, o, u, n, bz, dn);
            checkOutput({tag, "_pcount"}, {16'd0, n}, {16'd0, e.pcnt});
            checkOutput({tag, "_unstable"}, {16'd0, u}, {16'd0, e.unst});
            checkOutput({tag, "_busy"}, {31'd0, bz}, 32'd0);
            if (e.full) begin
                checkOutput({tag, "_sig"}, {16'd0, s}, {16'd0, e.sig});
                checkOutput({tag, "_ones"}, {16'd0, o}, {16'd0, e.ones});
                checkOutput({tag, "_pat"}, {6'd0, p}, {6'd0, e.pat});
            end
        end
    endtask

    initial begin
        int          cyc;
        logic [25:0] ep;
        rst    = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
        modeA  = 2'd0;
        modeB  = 2'd0;
        constA = 1'b0;
        constB = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_pat", {6'd0, patA}, 32'd0);
        checkOutput("rst_busy", {31'd0, busyA}, 32'd0);
        checkOutput("rst_done", {31'd0, doneA}, 32'd0);
        checkOutput("rst_sig", {16'd0, sigA}, 32'hFFFF);
        checkOutput("rst_counts", {onesA | unstA, pcntA}, 32'd0);
        checkOutput("rst_sigC", {16'd0, sigC}, 32'hFFFF);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] test 1: constant 0 response");
        sbq.push_back(runModel(26'h1, 4, 0, 3));
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1_busy", {31'd0, busyA}, 32'd1);
        checkOutput("t1_done", {31'd0, doneA}, 32'd0);
        checkOutput("t1_first_pat", {6'd0, patA}, 32'd1);
        waitDone(0, 100, cyc);
        checkOutput("t1_cycles", cyc, 32'd24);
        checkResult(0, "t1");

        $display("[TB] test 2: constant 1 response, restart from done, start ignored while busy");
        constA = 1'b1;
        ep     = 26'h1;
        for (int k = 0; k < 4; k++) begin
            patQ.push_back(ep);
            ep = lfsrNext(ep);
        end
        sbq.push_back(runModel(26'h1, 4, 1, 3));
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t2_cleared_pcount", {16'd0, pcntA}, 32'd0);
        checkOutput("t2_cleared_sig", {16'd0, sigA}, 32'hFFFF);
        checkOutput("t2_done_low", {31'd0, doneA}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                startA = 1'b1;
                @(negedge clk);
                startA = 1'b0;
                repeat (WA - 1) @(negedge clk);
            end else if (k > 0) begin
                repeat (WA) @(negedge clk);
            end
            checkOutput($sformatf("t2_pat%0d", k), {6'd0, patA}, {6'd0, patQ.pop_front()});
        end
        waitDone(0, 20, cyc);
        checkOutput("t2_tail_cycles", cyc, WA);
        checkResult(0, "t2");

        $display("[TB] test 3/6: toggling response, OBSERVE 3 and 1, zero seed");
        modeA = 2'd3;
        modeB = 2'd3;
        sbq.push_back(runModel(26'h1, 4, 3, 3));
        sbq.push_back(runModel(26'h0, 4, 3, 1));
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t6_zero_seed_pat", {6'd0, patB}, 32'd1);
        waitDone(0, 100, cyc);
        checkResult(0, "t3_obs3");
        waitDone(1, 100, cyc);
        checkResult(1, "t3_obs1");

        $display("[TB] test 5: reset mid-run, then fresh run");
        modeA  = 2'd0;
        constA = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (WA + 3) @(negedge clk);
        checkOutput("t5_midrun_pcount", {16'd0, pcntA}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_rst_pat", {6'd0, patA}, 32'd0);
        checkOutput("t5_rst_flags", {30'd0, busyA, doneA}, 32'd0);
        checkOutput("t5_rst_sig", {16'd0, sigA}, 32'hFFFF);
        checkOutput("t5_rst_counts", {onesA | unstA, pcntA}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        sbq.push_back(runModel(26'h1, 4, 0, 3));
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(0, 100, cyc);
        checkOutput("t5_cycles", cyc, 32'd24);
        checkResult(0, "t5");

        $display("[TB] test 4: response follows delayed pat_out[0], 256 patterns");
        sbq.push_back(runModel(26'h1, 256, 2, 4));
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitDone(2, 3000, cyc);
        checkOutput("t4_cycles", cyc, 256 * WC);
        checkResult(2, "t4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
